// File: rtl/fetch_pkg.sv
// Shared IF-stage definitions: field widths, reset PC, opcode slice and the buffered {pc,inst} entry.
package fetch_pkg;
  localparam int INST_W = 8;
  localparam int PC_W   = 8;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 8'h00;
  localparam int OP_MSB = 7;
  localparam int OP_LSB = 5;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_ent_t;

  typedef enum logic {ST_RUN = 1'b0, ST_HOLD = 1'b1} fetch_st_t;
endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc,inst} entries with a registered head for a 0-cycle output.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_ent_t               wdata,
  output fetch_ent_t               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  fetch_ent_t     mem [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic [AW-1:0]  rd_nxt;

  assign count  = wr_ptr - rd_ptr;
  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign rd_nxt = rd_ptr[AW-1:0] + AW'(1);

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Head is refreshed only when the visible entry changes, so it holds its value once drained or flushed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
        if (count == (AW+1)'(1)) begin
          if (push) head <= wdata;
        end else begin
          head <= mem[rd_nxt];
        end
      end else if (empty && push) begin
        head <= wdata;
      end
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// IF stage: fetch PC, imem req/ready handshake, RUN/HOLD flow control and branch redirect.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              DEPTH    = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic [PC_W-1:0]   imem_addr,
  output logic              imem_req,
  input  logic              imem_ready,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  input  logic              id_ready,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   PC
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_st_t        state;
  logic [PC_W-1:0]  fetch_pc;
  logic             push, pop, full, empty;
  logic [CW-1:0]    count;
  fetch_ent_t       head, wdata;

  assign imem_addr  = fetch_pc;
  assign imem_req   = (state == ST_RUN) & ~branch_taken;
  assign push       = imem_req & imem_ready;
  assign pop        = ~empty & id_ready & ~branch_taken;
  assign wdata      = '{pc: fetch_pc, inst: imem_rdata};
  assign inst_valid = ~empty;
  assign inst       = head.inst;
  assign PC         = head.pc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock  (clock),
    .reset_n(reset_n),
    .flush  (branch_taken),
    .push   (push),
    .pop    (pop),
    .wdata  (wdata),
    .head   (head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // Reset parks in HOLD so the first cycle after release issues no request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_HOLD;
      fetch_pc <= RESET_PC;
    end else if (branch_taken) begin
      state    <= ST_RUN;
      fetch_pc <= branch_target;
    end else begin
      if (push) fetch_pc <= fetch_pc + PC_W'(1);
      if (state == ST_RUN) begin
        if (push && !pop && count == CW'(DEPTH-1)) state <= ST_HOLD;
      end else begin
        if (pop || !full) state <= ST_RUN;
      end
    end
  end
endmodule
